// File: rtl/dpmem_arbiter_pkg.sv
// rtl/dpmem_arbiter_pkg.sv - shared widths, latency and read-tag types for the dual-port memory arbiter
package dpmem_arbiter_pkg;

  localparam int ADDR_W_DEF       = 14;
  localparam int DATA_W_DEF       = 32;
  localparam int READ_LATENCY_DEF = 2;
  localparam int ID_W             = 1;

  typedef logic [ID_W-1:0] req_id_t;

  // One stage of the in-flight read tracker.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dpmem_arbiter_rr_arb2.sv
// rtl/dpmem_arbiter_rr_arb2.sv - two-way round-robin picker; the pointer remembers the last granted id
module rr_arb2
  import dpmem_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       sel,
  output req_id_t    sel_id
);

  req_id_t last_id;

  always_comb begin
    sel = |req;
    if (req == 2'b11) begin
      sel_id = ~last_id;
    end else begin
      sel_id = req_id_t'(req[1]);
    end
  end

  // Reset to "last granted = 1" so requester 0 wins the first contest.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_id <= req_id_t'(1);
    end else if (advance) begin
      last_id <= sel_id;
    end
  end

endmodule

// File: rtl/dpmem_arbiter.sv
// rtl/dpmem_arbiter.sv - shares one write port and one read port of a dual-port bank between two requesters
module dpmem_arbiter
  import dpmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = READ_LATENCY_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_write,
  input  logic [ADDR_W-1:0] r0_address,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_write,
  input  logic [ADDR_W-1:0] r1_address,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [ADDR_W-1:0] mem_read_address,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [15:0]       collisions
);

  logic [1:0]        w_req;
  logic [1:0]        r_req;
  logic              w_sel;
  logic              r_sel;
  req_id_t           w_id;
  req_id_t           r_id;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_addr;
  logic              collide;
  logic              w_gnt;
  logic              r_gnt;
  logic              starve;

  rd_tag_t [READ_LATENCY-1:0] rd_pipe;

  assign w_req = {r1_valid & r1_write, r0_valid & r0_write};
  assign r_req = {r1_valid & ~r1_write, r0_valid & ~r0_write};

  rr_arb2 u_wr_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (w_req),
    .advance (w_gnt),
    .sel     (w_sel),
    .sel_id  (w_id)
  );

  rr_arb2 u_rd_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (r_req),
    .advance (r_gnt),
    .sel     (r_sel),
    .sel_id  (r_id)
  );

  assign w_addr = w_id[0] ? r1_address : r0_address;
  assign r_addr = r_id[0] ? r1_address : r0_address;

  // The bank cannot read and write one address in the same cycle; starve picks
  // which side yields so a held pair of requests alternates instead of locking out.
  assign collide = w_sel & r_sel & (w_addr == r_addr);
  assign w_gnt   = reset_n & w_sel & ~(collide & starve);
  assign r_gnt   = reset_n & r_sel & ~(collide & ~starve);

  assign r0_ready = (w_gnt & ~w_id[0]) | (r_gnt & ~r_id[0]);
  assign r1_ready = (w_gnt &  w_id[0]) | (r_gnt &  r_id[0]);

  assign mem_write_enable  = w_gnt;
  assign mem_write_address = w_addr;
  assign mem_write_data    = w_id[0] ? r1_wdata : r0_wdata;
  assign mem_read_address  = r_addr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve     <= 1'b0;
      collisions <= '0;
      rd_pipe    <= '0;
    end else begin
      if (r_gnt) begin
        starve <= 1'b0;
      end else if (collide) begin
        starve <= 1'b1;
      end
      if (collide) begin
        collisions <= sat_inc(collisions);
      end
      rd_pipe[0] <= '{valid: r_gnt, id: r_id};
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  assign rsp_valid = rd_pipe[READ_LATENCY-1].valid;
  assign rsp_id    = rd_pipe[READ_LATENCY-1].id[0];
  assign rsp_data  = mem_read_data;

endmodule

// File: tb/tb_dpmem_arbiter.sv
// tb/tb_dpmem_arbiter.sv - self-checking bench for dpmem_arbiter with a bank model and a behavioural reference
module tb_dpmem_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          r0_valid = 1'b0, r0_write = 1'b0;
  logic [AW-1:0] r0_address = '0;
  logic [DW-1:0] r0_wdata = '0;
  logic          r1_valid = 1'b0, r1_write = 1'b0;
  logic [AW-1:0] r1_address = '0;
  logic [DW-1:0] r1_wdata = '0;
  logic          r0_ready, r1_ready;
  logic          rsp_valid, rsp_id;
  logic [DW-1:0] rsp_data;
  logic          mem_write_enable;
  logic [AW-1:0] mem_write_address, mem_read_address;
  logic [DW-1:0] mem_write_data, mem_read_data;
  logic [15:0]   collisions;

  always #5 clock = ~clock;

  dpmem_arbiter dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .r0_valid          (r0_valid),
    .r0_ready          (r0_ready),
    .r0_write          (r0_write),
    .r0_address        (r0_address),
    .r0_wdata          (r0_wdata),
    .r1_valid          (r1_valid),
    .r1_ready          (r1_ready),
    .r1_write          (r1_write),
    .r1_address        (r1_address),
    .r1_wdata          (r1_wdata),
    .rsp_valid         (rsp_valid),
    .rsp_id            (rsp_id),
    .rsp_data          (rsp_data),
    .mem_write_enable  (mem_write_enable),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_read_address  (mem_read_address),
    .mem_read_data     (mem_read_data),
    .collisions        (collisions)
  );

  // Bank stand-in: read-first, two-cycle read latency.
  logic [DW-1:0] bank [0:(1<<AW)-1];
  logic [DW-1:0] bank_d1, bank_d2;
  always @(posedge clock) begin
    bank_d1 <= bank[mem_read_address];
    bank_d2 <= bank_d1;
    if (mem_write_enable) bank[mem_write_address] <= mem_write_data;
  end
  assign mem_read_data = bank_d2;

  int checks = 0;
  int errors = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model state
  typedef struct {int due; int id; logic [DW-1:0] data;} rsp_t;
  logic [DW-1:0] gold [0:(1<<AW)-1];
  rsp_t pend[$];
  int   m_last_w = 1, m_last_r = 1, m_count = 0, cyc = 0;
  bit   m_starve = 1'b0;

  function automatic logic [AW-1:0] addr_of(int i);
    return (i == 1) ? r1_address : r0_address;
  endfunction

  function automatic logic [DW-1:0] data_of(int i);
    return (i == 1) ? r1_wdata : r0_wdata;
  endfunction

  function automatic void decide(output bit wg, output int wid, output bit rg, output int rid,
                                 output bit coll);
    bit wc0, wc1, rc0, rc1, ws, rs;
    wc0 = r0_valid && r0_write;
    wc1 = r1_valid && r1_write;
    rc0 = r0_valid && !r0_write;
    rc1 = r1_valid && !r1_write;
    ws  = wc0 || wc1;
    rs  = rc0 || rc1;
    wid = (wc0 && wc1) ? 1 - m_last_w : (wc1 ? 1 : 0);
    rid = (rc0 && rc1) ? 1 - m_last_r : (rc1 ? 1 : 0);
    coll = ws && rs && (addr_of(wid) == addr_of(rid));
    wg = ws && !(coll && m_starve);
    rg = rs && !(coll && !m_starve);
  endfunction

  always @(posedge clock) begin : mdl
    bit wg, rg, coll;
    int wid, rid;
    rsp_t e;
    if (!reset_n) begin
      m_last_w = 1; m_last_r = 1; m_starve = 1'b0; m_count = 0;
      pend.delete();
    end else begin
      decide(wg, wid, rg, rid, coll);
      if (rg) begin
        e.due = cyc + 2; e.id = rid; e.data = gold[addr_of(rid)];
        pend.push_back(e);
      end
      if (wg) gold[addr_of(wid)] = data_of(wid);
      if (coll && m_count < 65535) m_count++;
      if (rg) m_starve = 1'b0;
      else if (coll) m_starve = 1'b1;
      if (wg) m_last_w = wid;
      if (rg) m_last_r = rid;
    end
    while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
    cyc++;
  end

  always @(negedge clock) begin : cmp
    bit wg, rg, coll, due;
    int wid, rid;
    if (!reset_n) begin
      check("rst_r0_ready", 32'(r0_ready), 32'd0);
      check("rst_r1_ready", 32'(r1_ready), 32'd0);
      check("rst_wen", 32'(mem_write_enable), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_collisions", 32'(collisions), 32'd0);
    end else begin
      decide(wg, wid, rg, rid, coll);
      check("r0_ready", 32'(r0_ready), 32'((wg && wid == 0) || (rg && rid == 0)));
      check("r1_ready", 32'(r1_ready), 32'((wg && wid == 1) || (rg && rid == 1)));
      check("mem_wen", 32'(mem_write_enable), 32'(wg));
      if (wg) begin
        check("mem_waddr", 32'(mem_write_address), 32'(addr_of(wid)));
        check("mem_wdata", mem_write_data, data_of(wid));
      end
      if (rg) check("mem_raddr", 32'(mem_read_address), 32'(addr_of(rid)));
      check("collisions", 32'(collisions), 32'(m_count));
      due = pend.size() > 0 && pend[0].due == cyc;
      check("rsp_valid", 32'(rsp_valid), 32'(due));
      if (due) begin
        check("rsp_id", 32'(rsp_id), 32'(pend[0].id));
        check("rsp_data", rsp_data, pend[0].data);
      end
    end
  end

  // Requester drivers: queued requests held until accepted.
  typedef struct {logic wr; logic [AW-1:0] addr; logic [DW-1:0] data;} req_t;
  req_t q0[$], q1[$];
  bit   stream = 1'b0;
  bit   acc0 = 1'b0, acc1 = 1'b0;

  always @(negedge clock) begin
    acc0 = r0_valid && r0_ready;
    acc1 = r1_valid && r1_ready;
  end

  always @(posedge clock) begin : drv
    #1;
    if (acc0 && q0.size() > 0) void'(q0.pop_front());
    if (acc1 && q1.size() > 0) void'(q1.pop_front());
    if (stream) begin
      r0_valid = 1'b1; r0_write = 1'b1; r0_address = 14'h40; r0_wdata = cyc;
      r1_valid = 1'b1; r1_write = 1'b0; r1_address = 14'h40; r1_wdata = '0;
    end else begin
      r0_valid = q0.size() > 0;
      if (q0.size() > 0) begin
        r0_write = q0[0].wr; r0_address = q0[0].addr; r0_wdata = q0[0].data;
      end
      r1_valid = q1.size() > 0;
      if (q1.size() > 0) begin
        r1_write = q1[0].wr; r1_address = q1[0].addr; r1_wdata = q1[0].data;
      end
    end
  end

  typedef struct {int id; logic [DW-1:0] data; int c;} log_t;
  log_t rlog[$];
  always @(negedge clock) begin : mon
    log_t e;
    if (reset_n && rsp_valid) begin
      e.id = 32'(rsp_id); e.data = rsp_data; e.c = cyc;
      rlog.push_back(e);
    end
  end

  task automatic push(int who, logic wr, logic [AW-1:0] a, logic [DW-1:0] d);
    req_t e;
    e.wr = wr; e.addr = a; e.data = d;
    if (who == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clock); #2;
    reset_n = 1'b0;
    @(negedge clock);
    check("dr_r0_ready", 32'(r0_ready), 32'd0);
    check("dr_r1_ready", 32'(r1_ready), 32'd0);
    check("dr_collisions", 32'(collisions), 32'd0);
    check("dr_rsp_valid", 32'(rsp_valid), 32'd0);
    q0.delete(); q1.delete(); stream = 1'b0;
    @(posedge clock); #2;
    reset_n = 1'b1;
  endtask

  task automatic wait_rsp(string nm, int eid, logic [DW-1:0] ed, int maxc);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < maxc) begin
      @(negedge clock);
      n++;
      if (rsp_valid) seen = 1'b1;
    end
    check({nm, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({nm, "_id"}, 32'(rsp_id), 32'(eid));
      check({nm, "_data"}, rsp_data, ed);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    @(negedge clock);
    check("init_collisions", 32'(collisions), 32'd0);
    check("init_rsp_valid", 32'(rsp_valid), 32'd0);
    check("init_wen", 32'(mem_write_enable), 32'd0);
    @(posedge clock); #2;
    reset_n = 1'b1;

    // Write then read the same word one cycle later.
    @(negedge clock); #1;
    push(0, 1'b1, 14'h10, 32'hDEADBEEF);
    @(negedge clock); #1;
    push(1, 1'b0, 14'h10, 32'h0);
    wait_rsp("t1", 1, 32'hDEADBEEF, 6);

    // Both requesters reading continuously alternate without bubbles.
    do_reset();
    @(negedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      push(0, 1'b1, AW'(32'h100 + i), DW'(32'h1000 + i));
      push(1, 1'b1, AW'(32'h200 + i), DW'(32'h2000 + i));
    end
    repeat (8) @(negedge clock);
    #1;
    rlog.delete();
    for (int i = 0; i < 3; i++) begin
      push(0, 1'b0, AW'(32'h100 + i), '0);
      push(1, 1'b0, AW'(32'h200 + i), '0);
    end
    repeat (10) @(negedge clock);
    check("t2_count", 32'(rlog.size()), 32'd6);
    if (rlog.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check("t2_id", 32'(rlog[i].id), 32'(i % 2));
        check("t2_data", rlog[i].data, 32'(((i % 2 == 1) ? 32'h2000 : 32'h1000) + i / 2));
        check("t2_cycle", 32'(rlog[i].c - rlog[0].c), 32'(i));
      end
    end

    // Single collision: write first, read next cycle sees the new data.
    do_reset();
    @(negedge clock); #1;
    push(0, 1'b1, 14'h20, 32'h1);
    push(1, 1'b0, 14'h20, 32'h0);
    wait_rsp("t3", 1, 32'h1, 6);
    check("t3_collisions", 32'(collisions), 32'd1);

    // Persistent writer cannot starve the reader.
    do_reset();
    @(negedge clock); #1;
    for (int i = 0; i < 4; i++) push(0, 1'b1, 14'h30, DW'(32'hA0 + i));
    push(1, 1'b0, 14'h30, 32'h0);
    repeat (3) @(negedge clock);
    check("t4_collisions", 32'(collisions), 32'd2);
    wait_rsp("t4", 1, 32'hA0, 4);
    repeat (6) @(negedge clock);
    check("t4_collisions_final", 32'(collisions), 32'd2);

    // Reset while reads are in flight drops their responses.
    do_reset();
    @(negedge clock); #1;
    push(0, 1'b0, 14'h10, 32'h0);
    push(1, 1'b0, 14'h20, 32'h0);
    push(0, 1'b0, 14'h30, 32'h0);
    repeat (2) @(posedge clock);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("t5_no_rsp", 32'(rsp_valid), 32'd0);
    end
    check("t5_collisions", 32'(collisions), 32'd0);

    // Saturation of the collision counter.
    do_reset();
    stream = 1'b1;
    repeat (65540) @(negedge clock);
    check("t6_saturated", 32'(collisions), 32'hFFFF);
    stream = 1'b0;
    repeat (4) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
